serial_add: RTL and testbench
=============================

Name: serial_add

Overview:
- Bit-serial unsigned adder; the addition counterpart of the team's 4-bit subtractor.
- Accepts two WIDTH-bit operands over a valid/ready handshake and adds them LSB-first, one bit per clock.
- Presents the sum and carry-out over a second valid/ready handshake.
- Used where area matters more than latency; the datapath is one full-adder bit plus shift registers.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 2..32

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a/b valid this cycle
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  first operand, unsigned
b  input  WIDTH  second operand, unsigned
out_valid  output  1  sum/carry_out valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  WIDTH  (a + b) mod 2^WIDTH
carry_out  output  1  bit WIDTH of a + b; 1 iff a + b >= 2^WIDTH

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: rst high at a rising edge forces the state to IDLE and clears all of the following:
  - shift registers
  - bit counter
  - carry flop
  - sum = 0, carry_out = 0, out_valid = 0
  - in_ready = 1 from the first cycle after reset
  - Applies in any state; an in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE (encoding free).
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid at an edge:
    - load a into shift register A and b into shift register B;
    - clear the carry flop and the counter;
    - go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready = 0, out_valid = 0; in_valid is ignored.
  - Each edge:
    - s = A[0] ^ B[0] ^ c;
    - c <= majority(A[0], B[0], c);
    - A and B shift right by 1;
    - the sum shift register shifts right with s inserted at MSB;
    - counter increments.
  - On the edge where counter == WIDTH-1 (WIDTH bits processed): go to DONE. carry_out takes the final carry.
- DONE:
  - out_valid = 1; sum and carry_out are held stable.
  - On out_ready at an edge, go to IDLE.
  - While out_ready = 0, stay in DONE indefinitely with outputs unchanged.
- Latency: operands accepted at edge k give out_valid high in the cycle after edge k+WIDTH (exactly WIDTH RUN cycles).
  - Throughput is one operation per WIDTH+2 cycles minimum (IDLE, WIDTH×RUN, DONE); there is no overlap of accept and deliver.
- sum and carry_out may change during RUN. Consumers sample them only when out_valid = 1.
- Width rule: the result is exactly a + b as a (WIDTH+1)-bit number, {carry_out, sum}.
- Simultaneous rst and in_valid/out_ready: rst wins.

Optional Feature:
- Macro: SERIAL_ADD_CIN_EN.
- Defined:
  - adds port carry_in (input, 1 bit), sampled with a/b at the accepting edge;
  - initial carry flop = carry_in;
  - result = a + b + carry_in.
- Undefined: no carry_in port; initial carry = 0. Timing is identical in both builds.

Test Plan:
- Reset then in_valid with a=4, b=0 (WIDTH=4) -> in_ready falls next cycle; out_valid high exactly 4 RUN cycles later; sum=4, carry_out=0; out_ready=1 returns to IDLE with in_ready=1.
- a=15, b=1 -> sum=0, carry_out=1. a=9, b=8 -> sum=1, carry_out=1. a=3, b=3 -> sum=6, carry_out=0. Each checked against a model of (a+b) split into {carry_out, sum}.
- Back-pressure: a=2, b=5, out_ready held 0 for 3 cycles in DONE -> out_valid stays 1, sum=7 constant, in_ready=0; out_ready=1 then completes.
- Operand change during RUN: in_valid=1 with a=1, b=1 in RUN -> ignored; result equals the operands accepted in IDLE.
- Reset mid-RUN: assert rst two cycles after accept -> next cycle IDLE, out_valid=0, sum=0, carry_out=0. A new a=4, b=4 then yields sum=8, carry_out=0.
- SERIAL_ADD_CIN_EN build: a=15, b=0, carry_in=1 -> sum=0, carry_out=1. a=4, b=2, carry_in=1 -> sum=7, carry_out=0.

Source files
------------

// File: rtl/serial_add.sv
// serial_add: bit-serial unsigned adder, LSB first, one bit per clock.
// Operands arrive over an in_valid/in_ready handshake. The result
// {carry_out, sum} is returned over an out_valid/out_ready handshake.
// Optional build macro SERIAL_ADD_CIN_EN adds a carry_in port. The carry flop
// then starts from carry_in instead of 0, and the result is a + b + carry_in.
module serial_add #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADD_CIN_EN
    ,
    input  logic             carry_in
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             co_r;
    logic             bit_s;
    logic             bit_c;
    logic             last;
    logic             c_init;

    // One full-adder bit operating on the current LSBs and the running carry.
    assign bit_s = a_sh[0] ^ b_sh[0] ^ c;
    assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign last  = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_CIN_EN
    assign c_init = carry_in;
`else
    assign c_init = 1'b0;
`endif

    assign sum       = sum_sh;
    assign carry_out = co_r;

    // State register; reset returns to IDLE and discards any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples values from before the edge, regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        // NOTE: every output receives a default first, so no path leaves a
        // value unassigned and no latch is inferred.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand load, serial add and result shift, and the final carry capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            co_r   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        cnt  <= '0;
                        c    <= c_init;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
                    c      <= bit_c;
                    cnt    <= cnt + 1'b1;
                    if (last) co_r <= bit_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: directed self-checking bench for serial_add with WIDTH=4.
// It checks reset, handshake timing, sums and carries, back-pressure,
// operands ignored during RUN, and reset during RUN.
// When SERIAL_ADD_CIN_EN is defined, it also checks the carry_in cases.
module tb_serial_add;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         cin_tb = 1'b0;

    int checks = 0;
    int errors = 0;

    serial_add #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADD_CIN_EN
        ,
        .carry_in  (cin_tb)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Run one operation. Inputs are driven and outputs sampled on negedges.
    // stall = number of DONE cycles held with out_ready=0.
    // junk  = keep in_valid high with a=1, b=1 throughout RUN.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic cin,
                          input logic [W-1:0] exp_sum, input logic exp_co,
                          input int stall, input logic junk);
        int n;
        logic [W:0] model;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        in_valid  = 1'b1;
        a         = op_a;
        b         = op_b;
        cin_tb    = cin;
        out_ready = 1'b0;
        @(negedge clk);
        check("run_in_ready", in_ready, 0);
        check("run_out_valid", out_valid, 0);
        if (junk) begin
            a = 4'd1;
            b = 4'd1;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("latency", n, W);
        check("sum", sum, exp_sum);
        check("carry_out", carry_out, exp_co);
        model = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, (W == 4 ? cin : 1'b0)};
        check("model", {carry_out, sum}, model);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_sum", sum, exp_sum);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("back_idle_in_ready", in_ready, 1);
        check("back_idle_out_valid", out_valid, 0);
    endtask

    initial begin
        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_carry_out", carry_out, 0);
        rst = 1'b0;

        // Basic operations, including carry out of the top bit.
        run_op(4'd4,  4'd0, 1'b0, 4'd4, 1'b0, 0, 1'b0);
        run_op(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 0, 1'b0);
        run_op(4'd9,  4'd8, 1'b0, 4'd1, 1'b1, 0, 1'b0);
        run_op(4'd3,  4'd3, 1'b0, 4'd6, 1'b0, 0, 1'b0);

        // Back-pressure: hold DONE for three cycles.
        run_op(4'd2,  4'd5, 1'b0, 4'd7, 1'b0, 3, 1'b0);

        // Operand change during RUN must be ignored.
        run_op(4'd6,  4'd7, 1'b0, 4'd13, 1'b0, 0, 1'b1);

        // Reset two cycles after accept discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'd15;
        b        = 4'd15;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_carry_out", carry_out, 0);
        run_op(4'd4,  4'd4, 1'b0, 4'd8, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADD_CIN_EN
        run_op(4'd15, 4'd0, 1'b1, 4'd0, 1'b1, 0, 1'b0);
        run_op(4'd4,  4'd2, 1'b1, 4'd7, 1'b0, 0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
